// File: rtl/snoop_pkg.sv
// Shared encodings and helpers for the multi-channel AXI-Stream snooper.
package snoop_pkg;

  localparam logic [0:0] CAP_WAIT = 1'b0;
  localparam logic [0:0] CAP_CAP  = 1'b1;

  localparam logic [1:0] TRK_SYNC = 2'd0;
  localparam logic [1:0] TRK_IDLE = 2'd1;
  localparam logic [1:0] TRK_BODY = 2'd2;

  // Keep vectors are zero-extended to 64 bits, covering TDATA up to 512 bits.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'b0, v[i]};
    return n;
  endfunction

  // First requester at or after ptr, wrapping within n channels.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input int ptr, input int n);
    logic [3:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx]) begin
        w     = 4'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/axis_multi_snooper_if.sv
// Snooped AXI-Stream links plus the packet-memory write port.
interface axis_multi_snooper_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH     = 4
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int LEN_W  = ADDR_WIDTH + $clog2(DATA_WIDTH / 8) + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_WIDTH-1:0] snoop_TDATA;
  logic [NUM_CH*KEEP_W-1:0]     snoop_TKEEP;
  logic [NUM_CH-1:0]            snoop_TVALID;
  logic [NUM_CH-1:0]            snoop_TREADY;
  logic [NUM_CH-1:0]            snoop_TLAST;
  logic                         mem_ready;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         wr_en;
  logic                         done;
  logic [LEN_W-1:0]             len_bytes;
  logic                         trunc;
  logic [CH_W-1:0]              cur_ch;

  modport master (
    output snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST, mem_ready,
    input  wr_addr, wr_data, wr_en, done, len_bytes, trunc, cur_ch
  );
  modport slave (
    input  snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST, mem_ready,
    output wr_addr, wr_data, wr_en, done, len_bytes, trunc, cur_ch
  );
endinterface

// File: rtl/axis_pkt_tracker.sv
// Per-channel packet boundary tracker; starts in SYNC so a packet cut by reset is ignored.
module axis_pkt_tracker
  import snoop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_ready,
  input  logic i_last,
  output logic o_is_start,
  output logic o_is_last
);
  logic [1:0] r_state;
  logic       w_acc;

  assign w_acc      = i_valid & i_ready;
  assign o_is_start = w_acc & (r_state == TRK_IDLE);
  assign o_is_last  = w_acc & i_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TRK_SYNC;
    end else if (w_acc) begin
      case (r_state)
        TRK_SYNC: if (i_last)  r_state <= TRK_IDLE;
        TRK_IDLE: if (!i_last) r_state <= TRK_BODY;
        TRK_BODY: if (i_last)  r_state <= TRK_IDLE;
        default:               r_state <= TRK_SYNC;
      endcase
    end
  end
endmodule

// File: rtl/axis_multi_snooper.sv
// Captures one whole packet at a time from NUM_CH snooped links into packet memory.
// Optional SNOOP_DROP_CNT_EN adds per-channel saturating dropped-packet counters.
module axis_multi_snooper
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH     = 4
) (
  input  logic clk,
  input  logic rst,
  axis_multi_snooper_if.slave bus
`ifdef SNOOP_DROP_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] drop_cnt
`endif
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int LEN_W  = ADDR_WIDTH + $clog2(DATA_WIDTH / 8) + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_tdata;
  logic [NUM_CH-1:0][KEEP_W-1:0]     w_tkeep;
  logic [NUM_CH-1:0]                 w_start, w_last, w_acc, w_grant;
  logic [CH_W-1:0]                   w_win, w_idx;
  logic                              w_take;
  logic [63:0]                       w_keep64;
  logic [7:0]                        w_pc;

  logic [0:0]            r_state;
  logic [CH_W-1:0]       r_rr_ptr, r_cur_ch;
  logic [ADDR_WIDTH-1:0] r_cnt, r_wr_addr;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en, r_done, r_trunc;
  logic [LEN_W-1:0]      r_len;

  assign w_tdata = bus.snoop_TDATA;
  assign w_tkeep = bus.snoop_TKEEP;
  assign w_acc   = bus.snoop_TVALID & bus.snoop_TREADY;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axis_pkt_tracker u_trk (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (bus.snoop_TVALID[c]),
      .i_ready   (bus.snoop_TREADY[c]),
      .i_last    (bus.snoop_TLAST[c]),
      .o_is_start(w_start[c]),
      .o_is_last (w_last[c])
    );
  end

  assign w_win  = CH_W'(rr_pick(16'(w_start), int'(r_rr_ptr), NUM_CH));
  assign w_take = (r_state == CAP_WAIT) & bus.mem_ready & (|w_start);
  assign w_idx  = (r_state == CAP_WAIT) ? w_win : r_cur_ch;
  assign w_pc   = popcount(w_keep64);

  always_comb begin
    w_keep64 = '0;
    w_keep64[KEEP_W-1:0] = w_tkeep[w_idx];
    w_grant = '0;
    if (w_take) w_grant[w_win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CAP_WAIT;
      r_rr_ptr  <= '0;
      r_cur_ch  <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_trunc   <= 1'b0;
      r_len     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
      case (r_state)
        CAP_WAIT: begin
          if (w_take) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= w_tdata[w_win];
            r_len     <= LEN_W'(w_pc);
            r_cur_ch  <= w_win;
            r_rr_ptr  <= (int'(w_win) == NUM_CH - 1) ? '0 : w_win + 1'b1;
            r_cnt     <= ADDR_WIDTH'(1);
            r_full    <= 1'b0;
            if (w_last[w_win]) r_done  <= 1'b1;
            else               r_state <= CAP_CAP;
          end
        end
        default: begin
          if (w_acc[r_cur_ch]) begin
            // Once the last word is written, later beats are only tracked for TLAST.
            if (!r_full) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt;
              r_wr_data <= w_tdata[r_cur_ch];
              r_len     <= r_len + LEN_W'(w_pc);
              r_cnt     <= r_cnt + 1'b1;
              if (r_cnt == '1) r_full <= 1'b1;
            end
            if (w_last[r_cur_ch]) begin
              r_done  <= 1'b1;
              r_trunc <= r_full;
              r_state <= CAP_WAIT;
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_en     = r_wr_en;
  assign bus.done      = r_done;
  assign bus.len_bytes = r_len;
  assign bus.trunc     = r_trunc;
  assign bus.cur_ch    = r_cur_ch;

`ifdef SNOOP_DROP_CNT_EN
  logic [NUM_CH-1:0]       w_drop;
  logic [NUM_CH-1:0][15:0] r_drop;

  assign w_drop   = w_start & ~w_grant;
  assign drop_cnt = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_drop[c] && r_drop[c] != 16'hFFFF) r_drop[c] <= r_drop[c] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_multi_snooper.sv
// Directed scoreboard bench for axis_multi_snooper (ADDR_WIDTH=2 so truncation is reachable).
module tb_axis_multi_snooper;
  localparam int DW = 64;
  localparam int AW = 2;
  localparam int NC = 4;
  localparam int KW = DW / 8;
  localparam int LW = AW + $clog2(DW / 8) + 1;

  typedef struct {
    bit            en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            done;
    logic [LW-1:0] len;
    bit            tr;
    logic [1:0]    ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_multi_snooper_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();
`ifdef SNOOP_DROP_CNT_EN
  logic [NC*16-1:0] drop_cnt;
`endif

  axis_multi_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SNOOP_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t e;
  logic [NC-1:0][DW-1:0] dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0][KW-1:0] kk(input int c, input logic [7:0] v);
    logic [NC-1:0][KW-1:0] k;
    k    = '0;
    k[c] = v;
    return k;
  endfunction

  task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] l,
                      input logic [NC-1:0][KW-1:0] k, input logic [NC-1:0] r = '1);
    for (int c = 0; c < NC; c++) dat[c] = {$urandom, $urandom};
    bus.snoop_TDATA  = dat;
    bus.snoop_TKEEP  = k;
    bus.snoop_TVALID = v;
    bus.snoop_TREADY = r;
    bus.snoop_TLAST  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step('0, '0, '0);
  endtask

  task automatic ex(input bit en, input int a, input int c, input bit dn, input int len, input bit tr);
    exp_t x;
    x.en   = en;
    x.addr = AW'(a);
    x.data = dat[c];
    x.done = dn;
    x.len  = LW'(len);
    x.tr   = tr;
    x.ch   = 2'(c);
    q.push_back(x);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(bus.wr_en), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_len"}, 64'(bus.len_bytes), 0);
    chk({tag, "_trunc"}, 64'(bus.trunc), 0);
    chk({tag, "_cur_ch"}, 64'(bus.cur_ch), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.wr_en !== 1'b0 || bus.done !== 1'b0)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(q.size()), 1);
      end else begin
        e = q.pop_front();
        chk("wr_en", 64'(bus.wr_en), 64'(e.en));
        if (e.en) begin
          chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          chk("wr_data", bus.wr_data, e.data);
        end
        chk("done", 64'(bus.done), 64'(e.done));
        if (e.done) begin
          chk("len_bytes", 64'(bus.len_bytes), 64'(e.len));
          chk("trunc", 64'(bus.trunc), 64'(e.tr));
        end
        chk("cur_ch", 64'(bus.cur_ch), 64'(e.ch));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.snoop_TDATA  = '0;
    bus.snoop_TKEEP  = '0;
    bus.snoop_TVALID = '0;
    bus.snoop_TREADY = '0;
    bus.snoop_TLAST  = '0;
    bus.mem_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
`ifdef SNOOP_DROP_CNT_EN
    chk("reset_drop_cnt", 64'(drop_cnt), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Bring every tracker out of SYNC; nothing captured.
    step('1, '1, {NC{8'hFF}});

    // 3-beat packet on ch0 with a not-ready stall in the middle.
    step(4'b0001, 4'b0000, kk(0, 8'hFF)); ex(1, 0, 0, 0, 8, 0);
    step(4'b0001, 4'b0000, kk(0, 8'hFF), 4'b1110);
    step(4'b0001, 4'b0000, kk(0, 8'hFF)); ex(1, 1, 0, 0, 16, 0);
    step(4'b0001, 4'b0001, kk(0, 8'h0F)); ex(1, 2, 0, 1, 20, 0);

    // Single-beat packet on ch1: FSM stays in WAIT, rr_ptr -> 2.
    step(4'b0010, 4'b0010, kk(1, 8'h01)); ex(1, 0, 1, 1, 1, 0);

    // Simultaneous starts on ch1 and ch3 with rr_ptr=2: ch3 wins.
    step(4'b1010, 4'b0000, kk(1, 8'hFF) | kk(3, 8'hFF)); ex(1, 0, 3, 0, 8, 0);
    step(4'b1010, 4'b1010, kk(1, 8'hFF) | kk(3, 8'hFF)); ex(1, 1, 3, 1, 16, 0);

    // rr_ptr wrapped to 0: ch0 beats ch1.
    step(4'b0011, 4'b0011, kk(0, 8'hFF) | kk(1, 8'hFF)); ex(1, 0, 0, 1, 8, 0);

    // TLAST on ch2 with a start on ch0 in the same cycle: ch0 packet dropped.
    step(4'b0100, 4'b0000, kk(2, 8'hFF)); ex(1, 0, 2, 0, 8, 0);
    step(4'b0101, 4'b0100, kk(0, 8'hFF) | kk(2, 8'hFF)); ex(1, 1, 2, 1, 16, 0);
    step(4'b0001, 4'b0001, kk(0, 8'hFF));

    // 6-beat packet overflows the 4-word memory.
    for (int i = 0; i < 6; i++) begin
      step(4'b0001, (i == 5) ? 4'b0001 : 4'b0000, kk(0, 8'hFF));
      if (i < 4)       ex(1, i, 0, 0, 8 * (i + 1), 0);
      else if (i == 5) ex(0, 0, 0, 1, 32, 1);
    end

    // Exactly fills memory: no truncation.
    for (int i = 0; i < 4; i++) begin
      step(4'b0010, (i == 3) ? 4'b0010 : 4'b0000, kk(1, 8'hFF));
      ex(1, i, 1, i == 3, 8 * (i + 1), 0);
    end

    // Start while mem_ready=0 drops the packet even after mem_ready rises.
    bus.mem_ready = 1'b0;
    step(4'b0100, 4'b0000, kk(2, 8'hFF));
    bus.mem_ready = 1'b1;
    step(4'b0100, 4'b0000, kk(2, 8'hFF));
    step(4'b0100, 4'b0100, kk(2, 8'hFF));
    step(4'b0100, 4'b0100, kk(2, 8'h3F)); ex(1, 0, 2, 1, 6, 0);

    // mem_ready falling during capture is ignored; sparse keep counted by popcount.
    step(4'b1000, 4'b0000, kk(3, 8'hFF)); ex(1, 0, 3, 0, 8, 0);
    bus.mem_ready = 1'b0;
    step(4'b1000, 4'b1000, kk(3, 8'hA5)); ex(1, 1, 3, 1, 12, 0);
    bus.mem_ready = 1'b1;
    idle();
    idle();

`ifdef SNOOP_DROP_CNT_EN
    chk("drop_cnt_ch0", 64'(drop_cnt[15:0]), 1);
    chk("drop_cnt_ch1", 64'(drop_cnt[31:16]), 2);
    chk("drop_cnt_ch2", 64'(drop_cnt[47:32]), 1);
    chk("drop_cnt_ch3", 64'(drop_cnt[63:48]), 0);
`endif

    // Reset in the middle of a ch2 packet.
    step(4'b0100, 4'b0000, kk(2, 8'hFF)); ex(1, 0, 2, 0, 8, 0);
    step(4'b0100, 4'b0000, kk(2, 8'hFF)); ex(1, 1, 2, 0, 16, 0);
    bus.snoop_TVALID = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
`ifdef SNOOP_DROP_CNT_EN
    chk("midreset_drop_cnt", 64'(drop_cnt), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b0100, (i == 3) ? 4'b0100 : 4'b0000, kk(2, 8'hFF));
    step(4'b0100, 4'b0000, kk(2, 8'hFF)); ex(1, 0, 2, 0, 8, 0);
    step(4'b0100, 4'b0100, kk(2, 8'h0F)); ex(1, 1, 2, 1, 12, 0);
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_leftover", 64'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
